// File: rtl/rs232_pkg.sv
// rs232_pkg: shared line levels, receiver states and oversampling constants for the rs232 DCE receiver
package rs232_pkg;
  localparam logic MARK = 1'b1;
  localparam logic SPACE = 1'b0;
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_POINT = 7;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
  function automatic int tick_div(input int clk_freq, input int baud_rate);
    int d;
    d = clk_freq / (OVERSAMPLE * baud_rate);
    return d < 1 ? 1 : d;
  endfunction
endpackage

// File: rtl/rs232_dce_rx_if.sv
// rs232_dce_rx_if: valid/ready receive stream; master = receiver (m_data, m_valid out, m_ready in), slave = consumer
interface rs232_dce_rx_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] m_data;
  logic m_valid;
  logic m_ready;
  modport master (output m_data, m_valid, input m_ready);
  modport slave (input m_data, m_valid, output m_ready);
endinterface

// File: rtl/rs232_rx_fifo.sv
// rs232_rx_fifo: synchronous receive FIFO with occupancy count
//   clk, rst_n       clock, async active-low reset
//   push, wdata      write request (accepted when not full, or when full and popping)
//   pop              read request (ignored when empty)
//   rdata            head word; holds the last popped word while empty
//   count            entries stored, 0..DEPTH
module rs232_rx_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [CW-1:0] count
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] last;
  logic wr, rd;
  assign rd = pop && count != '0;
  assign wr = push && (count != CW'(DEPTH) || rd);
  assign rdata = count != '0 ? mem[rd_ptr] : last;
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      last <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) begin
        rd_ptr <= rd_ptr + AW'(1);
        last <= mem[rd_ptr];
      end
      count <= count + CW'(wr) - CW'(rd);
    end
endmodule

// File: rtl/rs232_dce_rx.sv
// rs232_dce_rx: DCE-side rs232 receiver; deserialises txd into a FIFO-backed valid/ready stream and drives cts/dsr/dcd
//   clk, rst_n           clock, async active-low reset
//   txd, rts, dtr        DTE line inputs (synchronised internally)
//   rxd                  DCE-to-DTE line, held MARK
//   cts, dsr, dcd        registered handshake outputs
//   frame_err            1-cycle pulse on a SPACE stop bit
//   overrun_err          1-cycle pulse when a word completes into a full FIFO
//   parity_err           1-cycle pulse on even-parity mismatch (only with RS232_PARITY_EN)
//   m                    receive stream (rs232_dce_rx_if.master)
// Build option RS232_PARITY_EN adds one even-parity bit per frame.
module rs232_dce_rx
  import rs232_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_WIDTH = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int CTS_HEADROOM = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic txd,
  input  logic rts,
  input  logic dtr,
  output logic rxd,
  output logic cts,
  output logic dsr,
  output logic dcd,
  output logic frame_err,
  output logic overrun_err,
`ifdef RS232_PARITY_EN
  output logic parity_err,
`endif
  rs232_dce_rx_if.master m
);
  localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD_RATE);
  localparam int TW = $clog2(TICK_DIV) + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(DATA_WIDTH) + 1;
  logic [1:0] txd_q, rts_q, dtr_q;
  logic txd_s;
  logic [TW-1:0] tick_cnt;
  logic tick, sample, bit_end, push, pop, full, par_bad, stop_idx;
  logic [3:0] samp;
  logic [BW-1:0] bit_idx;
  logic [DATA_WIDTH-1:0] sh, rdata;
  logic [CW-1:0] count;
  rx_state_t state;
  assign txd_s = txd_q[1];
  assign rxd = MARK;
  assign tick = tick_cnt == TW'(TICK_DIV - 1);
  assign sample = tick && samp == 4'(SAMPLE_POINT);
  assign bit_end = tick && samp == 4'(OVERSAMPLE - 1);
  assign push = state == STOP && sample && txd_s == MARK && stop_idx == 1'(STOP_WIDTH - 1) && !par_bad;
  assign pop = m.m_valid && m.m_ready;
  assign full = count == CW'(FIFO_DEPTH);
  assign m.m_valid = count != '0;
  assign m.m_data = rdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      txd_q <= 2'b11;
      rts_q <= 2'b00;
      dtr_q <= 2'b00;
    end else begin
      txd_q <= {txd_q[0], txd};
      rts_q <= {rts_q[0], rts};
      dtr_q <= {dtr_q[0], dtr};
    end
  // Re-phase the oversampling tick to the start edge so sample 7 lands mid-bit.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tick_cnt <= '0;
    else tick_cnt <= (state == IDLE && txd_s == SPACE) || tick ? '0 : tick_cnt + TW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      samp <= '0;
      bit_idx <= '0;
      stop_idx <= 1'b0;
      sh <= '0;
      frame_err <= 1'b0;
`ifdef RS232_PARITY_EN
      parity_err <= 1'b0;
      par_bad <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef RS232_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (tick) samp <= samp + 4'd1;
      case (state)
        IDLE:
          if (txd_s == SPACE) begin
            state <= START;
            samp <= '0;
`ifdef RS232_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
        START:
          if (sample && txd_s == MARK) state <= IDLE;
          else if (bit_end) begin
            state <= DATA;
            bit_idx <= '0;
          end
        DATA: begin
          if (sample) sh <= {txd_s, sh[DATA_WIDTH-1:1]};
          if (bit_end) begin
            bit_idx <= bit_idx + BW'(1);
            stop_idx <= 1'b0;
`ifdef RS232_PARITY_EN
            if (bit_idx == BW'(DATA_WIDTH - 1)) state <= PARITY;
`else
            if (bit_idx == BW'(DATA_WIDTH - 1)) state <= STOP;
`endif
          end
        end
`ifdef RS232_PARITY_EN
        PARITY: begin
          if (sample) begin
            par_bad <= (^sh) != txd_s;
            parity_err <= (^sh) != txd_s;
          end
          if (bit_end) state <= STOP;
        end
`endif
        // Leaving at the last stop sample lets a back-to-back start edge be seen in time.
        STOP:
          if (sample) begin
            if (txd_s == SPACE) begin
              frame_err <= 1'b1;
              state <= BREAK;
            end else if (stop_idx == 1'(STOP_WIDTH - 1)) state <= IDLE;
            else stop_idx <= 1'b1;
          end
        BREAK:
          if (txd_s == MARK) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
`ifndef RS232_PARITY_EN
  assign par_bad = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cts <= 1'b0;
      dsr <= 1'b0;
      dcd <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      cts <= rts_q[1] && count < CW'(FIFO_DEPTH - CTS_HEADROOM);
      dsr <= 1'b1;
      dcd <= dtr_q[1];
      overrun_err <= push && full && !pop;
    end
  rs232_rx_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .wdata(sh),
    .pop(pop),
    .rdata(rdata),
    .count(count)
  );
endmodule

// File: tb/tb_rs232_dce_rx.sv
// tb_rs232_dce_rx: scoreboard bench for rs232_dce_rx at 16 clk per bit
module tb_rs232_dce_rx;
`ifdef RS232_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif
  logic clk = 1'b0, rst_n = 1'b0, txd = 1'b1, rts = 1'b1, dtr = 1'b1;
  logic rxd, cts, dsr, dcd, frame_err, overrun_err;
`ifdef RS232_PARITY_EN
  logic parity_err;
`endif
  int checks = 0, failures = 0;
  int fe_n = 0, ov_n = 0, pe_n = 0;
  logic [7:0] exp_q [$];
  rs232_dce_rx_if #(.DATA_WIDTH(8)) bus ();
  rs232_dce_rx #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .txd(txd),
    .rts(rts),
    .dtr(dtr),
    .rxd(rxd),
    .cts(cts),
    .dsr(dsr),
    .dcd(dcd),
    .frame_err(frame_err),
    .overrun_err(overrun_err),
`ifdef RS232_PARITY_EN
    .parity_err(parity_err),
`endif
    .m(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input bit bad_stop, input bit bad_par);
    @(negedge clk);
    txd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      txd = d[i];
      repeat (16) @(negedge clk);
    end
`ifdef RS232_PARITY_EN
    txd = (^d) ^ bad_par;
    repeat (16) @(negedge clk);
`else
    if (bad_par) $display("note: parity not built in");
`endif
    txd = !bad_stop;
    repeat (16) @(negedge clk);
    txd = 1'b1;
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (frame_err) fe_n++;
      if (overrun_err) ov_n++;
`ifdef RS232_PARITY_EN
      if (parity_err) pe_n++;
`endif
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_word: got %0h expected none", bus.m_data);
        end else chk("rx_word", bus.m_data, exp_q.pop_front());
      end
    end
  initial begin
    #500_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    int n, f0, o0;
    logic [7:0] w;
    bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rxd", rxd, 1);
    chk("rst_cts", cts, 0);
    chk("rst_dsr", dsr, 0);
    chk("rst_dcd", dcd, 0);
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_data", bus.m_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun_err, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("dsr_up", dsr, 1);
    chk("dcd_up", dcd, 1);
    chk("cts_up", cts, 1);
    exp_q.push_back(8'hA5);
    n = 0;
    fork
      send_frame(8'hA5, 0, 0);
      begin
        @(negedge clk);
        while (!bus.m_valid && n < 300) begin
          @(negedge clk);
          n++;
        end
        chk("a5_latency", n >= LAT - 3 && n <= LAT + 3, 1);
        @(negedge clk);
        chk("a5_valid_1cycle", bus.m_valid, 0);
      end
    join
    repeat (20) @(negedge clk);
    chk("a5_received", exp_q.size(), 0);
    f0 = fe_n;
    txd = 1'b0;
    repeat (4) @(negedge clk);
    txd = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_valid", bus.m_valid, 0);
    chk("glitch_frame_err", fe_n, f0);
    send_frame(8'h3C, 1, 0);
    repeat (20) @(negedge clk);
    chk("frame_err_count", fe_n, f0 + 1);
    chk("frame_err_no_push", bus.m_valid, 0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 0, 0);
    repeat (20) @(negedge clk);
    chk("after_break_received", exp_q.size(), 0);
    bus.m_ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      w = 8'(k * 17 + 3);
      exp_q.push_back(w);
      send_frame(w, 0, 0);
      repeat (2) @(negedge clk);
      chk($sformatf("cts_after_%0d", k), cts, k < 12);
    end
    o0 = ov_n;
    send_frame(8'hEE, 0, 0);
    repeat (4) @(negedge clk);
    chk("overrun_count", ov_n, o0 + 1);
    chk("full_valid", bus.m_valid, 1);
    chk("full_head", bus.m_data, 8'd20);
    bus.m_ready = 1'b1;
    repeat (40) @(negedge clk);
    chk("drain_all", exp_q.size(), 0);
    chk("drain_cts", cts, 1);
    chk("empty_holds_last", bus.m_data, 8'(16 * 17 + 3));
    bus.m_ready = 1'b0;
    send_frame(8'h99, 0, 0);
    repeat (4) @(negedge clk);
    chk("pre_reset_valid", bus.m_valid, 1);
    txd = 1'b0;
    repeat (16) @(negedge clk);
    txd = 1'b1;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_valid", bus.m_valid, 0);
    chk("midrst_data", bus.m_data, 0);
    chk("midrst_cts", cts, 0);
    chk("midrst_dsr", dsr, 0);
    chk("midrst_dcd", dcd, 0);
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    f0 = fe_n;
    repeat (20) @(negedge clk);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 0, 0);
    repeat (20) @(negedge clk);
    chk("post_reset_received", exp_q.size(), 0);
    chk("post_reset_no_frame_err", fe_n, f0);
`ifdef RS232_PARITY_EN
    n = pe_n;
    send_frame(8'h07, 0, 1);
    repeat (20) @(negedge clk);
    chk("parity_err_count", pe_n, n + 1);
    chk("parity_no_push", bus.m_valid, 0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 0, 0);
    repeat (20) @(negedge clk);
    chk("parity_good_received", exp_q.size(), 0);
    chk("parity_err_total", pe_n, n + 1);
`endif
    chk("overrun_total", ov_n, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
